// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: each channel produces a 50% duty divided
// clock plus a one-cycle tick, with glitch-free divisor reloads and a global phase sync.
module clock_divider_multi #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 25,
    parameter int DEF_DIV = 25000
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic [NUM_CH-1:0]         En,
    input  logic [NUM_CH*CNT_W-1:0]   DivIn,
    input  logic [NUM_CH-1:0]         DivLd,
    input  logic                      Sync,
    output logic [NUM_CH-1:0]         ClkOut,
    output logic [NUM_CH-1:0]         Tick,
    output logic [NUM_CH*CNT_W-1:0]   DivAct
);

    localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1'b1);

    logic [CNT_W-1:0]  cnt_r  [NUM_CH];
    logic [CNT_W-1:0]  cnt_s  [NUM_CH];
    logic [CNT_W-1:0]  act_r  [NUM_CH];
    logic [CNT_W-1:0]  act_s  [NUM_CH];
    logic [CNT_W-1:0]  pend_r [NUM_CH];
    logic [CNT_W-1:0]  pend_s [NUM_CH];
    logic [NUM_CH-1:0] pendv_r;
    logic [NUM_CH-1:0] pendv_s;
    logic [NUM_CH-1:0] clk_r;
    logic [NUM_CH-1:0] clk_s;
    logic [NUM_CH-1:0] tick_r;
    logic [NUM_CH-1:0] tick_s;

    // Next-state for every channel: Sync beats disable, disable beats terminal count.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_s[i]   = cnt_r[i];
            act_s[i]   = act_r[i];
            pend_s[i]  = pend_r[i];
            pendv_s[i] = pendv_r[i];
            clk_s[i]   = clk_r[i];
            tick_s[i]  = 1'b0;

            if (Sync) begin
                cnt_s[i] = ZERO_C;
                clk_s[i] = 1'b0;
                if (pendv_r[i]) begin
                    act_s[i] = pend_r[i];
                end else begin
                    act_s[i] = act_r[i];
                end
                // A load in the sync cycle is kept for the next terminal count.
                if (DivLd[i]) begin
                    pend_s[i]  = DivIn[i*CNT_W +: CNT_W];
                    pendv_s[i] = 1'b1;
                end else begin
                    pendv_s[i] = 1'b0;
                end
            end else if (!En[i]) begin
                cnt_s[i] = ZERO_C;
                clk_s[i] = 1'b0;
                if (DivLd[i]) begin
                    act_s[i]   = DivIn[i*CNT_W +: CNT_W];
                    pendv_s[i] = 1'b0;
                end else begin
                    act_s[i]   = act_r[i];
                end
            end else if (cnt_r[i] == act_r[i]) begin
                cnt_s[i]  = ZERO_C;
                clk_s[i]  = ~clk_r[i];
                tick_s[i] = 1'b1;
                if (pendv_r[i]) begin
                    act_s[i] = pend_r[i];
                end else begin
                    act_s[i] = act_r[i];
                end
                // The terminal consumes the old pending value; a coincident load waits.
                if (DivLd[i]) begin
                    pend_s[i]  = DivIn[i*CNT_W +: CNT_W];
                    pendv_s[i] = 1'b1;
                end else begin
                    pendv_s[i] = 1'b0;
                end
            end else begin
                cnt_s[i] = cnt_r[i] + ONE_C;
                if (DivLd[i]) begin
                    pend_s[i]  = DivIn[i*CNT_W +: CNT_W];
                    pendv_s[i] = 1'b1;
                end else begin
                    pend_s[i]  = pend_r[i];
                end
            end
        end
    end

    // Channel state registers with asynchronous reset to the default divisor.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i]  <= ZERO_C;
                act_r[i]  <= DEF_DIV_C;
                pend_r[i] <= ZERO_C;
            end
            pendv_r <= {NUM_CH{1'b0}};
            clk_r   <= {NUM_CH{1'b0}};
            tick_r  <= {NUM_CH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i]  <= cnt_s[i];
                act_r[i]  <= act_s[i];
                pend_r[i] <= pend_s[i];
            end
            pendv_r <= pendv_s;
            clk_r   <= clk_s;
            tick_r  <= tick_s;
        end
    end

    assign ClkOut = clk_r;
    assign Tick   = tick_r;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_readback
        assign DivAct[g*CNT_W +: CNT_W] = act_r[g];
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi: a vector table for steady-state division and
// disabled loads, plus hand sequences for reloads, disable, sync and mid-run reset.
module tb_clock_divider_multi;

    logic        Clk;
    logic        Rst_n;
    logic [1:0]  En;
    logic [15:0] DivIn;
    logic [1:0]  DivLd;
    logic        Sync;
    logic [1:0]  ClkOut;
    logic [1:0]  Tick;
    logic [15:0] DivAct;

    int checks;
    int errors;

    typedef struct {
        logic [1:0] en;
        logic [1:0] ld;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       sync;
        logic [1:0] exp_clk;
        logic [1:0] exp_tick;
        logic [7:0] exp_a0;
        logic [7:0] exp_a1;
    } vec_t;

    vec_t vecs [13];

    clock_divider_multi #(
        .NUM_CH  (2),
        .CNT_W   (8),
        .DEF_DIV (3)
    ) dut (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .En     (En),
        .DivIn  (DivIn),
        .DivLd  (DivLd),
        .Sync   (Sync),
        .ClkOut (ClkOut),
        .Tick   (Tick),
        .DivAct (DivAct)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        #2 Rst_n = 1'b0;
        #1;
        @(posedge Clk);
        #1 Rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Rst_n  = 1'b1;
        En     = 2'b00;
        DivIn  = 16'h0000;
        DivLd  = 2'b00;
        Sync   = 1'b0;

        // en, ld, d0, d1, sync, clk, tick, act0, act1
        vecs[0]  = '{2'b11, 2'b00, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00, 8'd3, 8'd3};
        vecs[1]  = '{2'b11, 2'b00, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00, 8'd3, 8'd3};
        vecs[2]  = '{2'b11, 2'b00, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00, 8'd3, 8'd3};
        vecs[3]  = '{2'b11, 2'b00, 8'd0, 8'd0, 1'b0, 2'b11, 2'b11, 8'd3, 8'd3};
        vecs[4]  = '{2'b11, 2'b00, 8'd0, 8'd0, 1'b0, 2'b11, 2'b00, 8'd3, 8'd3};
        vecs[5]  = '{2'b11, 2'b00, 8'd0, 8'd0, 1'b0, 2'b11, 2'b00, 8'd3, 8'd3};
        vecs[6]  = '{2'b11, 2'b00, 8'd0, 8'd0, 1'b0, 2'b11, 2'b00, 8'd3, 8'd3};
        vecs[7]  = '{2'b11, 2'b00, 8'd0, 8'd0, 1'b0, 2'b00, 2'b11, 8'd3, 8'd3};
        vecs[8]  = '{2'b10, 2'b01, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00, 8'd0, 8'd3};
        vecs[9]  = '{2'b11, 2'b00, 8'd0, 8'd0, 1'b0, 2'b01, 2'b01, 8'd0, 8'd3};
        vecs[10] = '{2'b11, 2'b00, 8'd0, 8'd0, 1'b0, 2'b00, 2'b01, 8'd0, 8'd3};
        vecs[11] = '{2'b11, 2'b00, 8'd0, 8'd0, 1'b0, 2'b11, 2'b11, 8'd0, 8'd3};
        vecs[12] = '{2'b11, 2'b00, 8'd0, 8'd0, 1'b0, 2'b10, 2'b01, 8'd0, 8'd3};

        // Asynchronous reset state, before any clock edge.
        #2 Rst_n = 1'b0;
        #1;
        chk("rst_clkout", ClkOut, 2'b00);
        chk("rst_tick",   Tick,   2'b00);
        chk("rst_divact", DivAct, 16'h0303);
        @(posedge Clk);
        #1 Rst_n = 1'b1;

        // Default divisor running, then a disabled-channel load of zero.
        for (int v = 0; v < 13; v++) begin
            En    = vecs[v].en;
            DivLd = vecs[v].ld;
            DivIn = {vecs[v].d1, vecs[v].d0};
            Sync  = vecs[v].sync;
            step(1);
            checks++;
            if (ClkOut !== vecs[v].exp_clk || Tick !== vecs[v].exp_tick ||
                DivAct !== {vecs[v].exp_a1, vecs[v].exp_a0}) begin
                errors++;
                $display("FAIL vec%0d: got clk=%b tick=%b act=%h expected clk=%b tick=%b act=%h",
                         v, ClkOut, Tick, DivAct, vecs[v].exp_clk, vecs[v].exp_tick,
                         {vecs[v].exp_a1, vecs[v].exp_a0});
            end
        end

        // Reload mid half-period takes effect only at the terminal count.
        En = 2'b00; DivLd = 2'b01; DivIn = {8'd0, 8'd9};
        step(1);
        chk("t3_load9", DivAct[7:0], 8'd9);
        DivLd = 2'b00; En = 2'b01;
        step(4);
        DivLd = 2'b01; DivIn = {8'd0, 8'd2};
        step(1);
        DivLd = 2'b00;
        chk("t3_act_hold", DivAct[7:0], 8'd9);
        step(4);
        chk("t3_still_low", ClkOut[0], 1'b0);
        step(1);
        chk("t3_rise10", ClkOut[0], 1'b1);
        chk("t3_tick10", Tick[0], 1'b1);
        chk("t3_act2", DivAct[7:0], 8'd2);
        step(2);
        chk("t3_high", ClkOut[0], 1'b1);
        chk("t3_notick", Tick[0], 1'b0);
        step(1);
        chk("t3_fall3", ClkOut[0], 1'b0);
        chk("t3_tick3", Tick[0], 1'b1);
        step(2);
        DivLd = 2'b01; DivIn = {8'd0, 8'd5};
        step(1);
        DivLd = 2'b00;
        chk("t3_coinc_clk", ClkOut[0], 1'b1);
        chk("t3_coinc_act", DivAct[7:0], 8'd2);
        step(3);
        chk("t3_next_clk", ClkOut[0], 1'b0);
        chk("t3_next_act", DivAct[7:0], 8'd5);

        // Disable mid high phase, then re-enable from a zero count.
        pulse_reset();
        En = 2'b10;
        step(4);
        chk("t4_rise", ClkOut[1], 1'b1);
        chk("t4_tick", Tick[1], 1'b1);
        step(1);
        En = 2'b00;
        step(1);
        chk("t4_dis_clk", ClkOut[1], 1'b0);
        chk("t4_dis_tick", Tick[1], 1'b0);
        step(2);
        En = 2'b10;
        step(3);
        chk("t4_reen_low", ClkOut[1], 1'b0);
        step(1);
        chk("t4_reen_rise", ClkOut[1], 1'b1);
        chk("t4_reen_tick", Tick[1], 1'b1);

        // Sync aligns channels, applies old pending and keeps a coincident load pending.
        En = 2'b00; DivLd = 2'b11; DivIn = {8'd7, 8'd1};
        step(1);
        chk("t5_load", DivAct, 16'h0701);
        DivLd = 2'b00; En = 2'b11;
        step(3);
        DivLd = 2'b10; DivIn = {8'd3, 8'd0};
        step(1);
        chk("t5_pend_hold", DivAct[15:8], 8'd7);
        DivLd = 2'b10; DivIn = {8'd9, 8'd0}; Sync = 1'b1;
        step(1);
        DivLd = 2'b00; Sync = 1'b0;
        chk("t5_sync_clk", ClkOut, 2'b00);
        chk("t5_sync_tick", Tick, 2'b00);
        chk("t5_sync_act", DivAct, 16'h0301);
        step(2);
        chk("t5_ch0_rise_clk", ClkOut, 2'b01);
        chk("t5_ch0_rise_tick", Tick, 2'b01);
        step(2);
        chk("t5_ch1_rise_clk", ClkOut, 2'b10);
        chk("t5_ch1_rise_tick", Tick, 2'b11);
        chk("t5_ch1_newact", DivAct[15:8], 8'd9);

        // Mid-period reset discards a pending divisor.
        DivLd = 2'b01; DivIn = {8'd0, 8'd5};
        step(1);
        DivLd = 2'b00;
        #2 Rst_n = 1'b0;
        #1;
        chk("t6_async_clk", ClkOut, 2'b00);
        chk("t6_async_tick", Tick, 2'b00);
        chk("t6_async_act", DivAct, 16'h0303);
        @(posedge Clk);
        #1 Rst_n = 1'b1;
        En = 2'b01;
        step(4);
        chk("t6_rise", ClkOut[0], 1'b1);
        chk("t6_act_kept", DivAct[7:0], 8'd3);
        step(4);
        chk("t6_fall", ClkOut[0], 1'b0);
        chk("t6_act_final", DivAct[7:0], 8'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
